// File: rtl/cpu_core.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_core
//  Description : Single-cycle RV32I integer-subset core with an internal
//                instruction ROM, a 32x32 register file and a RAW-hazard
//                unit that inserts a one-cycle bubble when the current
//                instruction reads the register written by the previous one.
//  Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  Register file: two combinational read ports, one synchronous write port.
//  x0 reads as zero and ignores writes.
// ----------------------------------------------------------------------------
module cpu_core_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  logic [31:0] registradores [0:31];

  // Clear every register on reset; otherwise perform the single write.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        registradores[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      registradores[i_waddr] <= i_wdata;
    end
  end

  // Combinational reads; x0 is forced to zero at the port.
  always_comb begin
    o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : registradores[i_raddr1];
    o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : registradores[i_raddr2];
  end

endmodule

// ----------------------------------------------------------------------------
//  Core top
// ----------------------------------------------------------------------------
module cpu_core #(
  parameter int                       IMEM_DEPTH = 64,
  parameter logic [31:0]              NOP_WORD   = 32'h00000013,
  parameter int                       PROG_WORDS = 16,
  parameter logic [PROG_WORDS*32-1:0] PROGRAM    = {{(PROG_WORDS-5){NOP_WORD}},
                                                    32'hffb08293, 32'h40208233,
                                                    32'h002081b3, 32'h00300113,
                                                    32'h00a00093}
) (
  input  logic clock,
  input  logic reset
);

  localparam int          AW        = $clog2(IMEM_DEPTH);
  localparam logic [31:0] c_PC_LAST = 32'(IMEM_DEPTH * 4 - 4);
  localparam logic [6:0]  c_OPC_OP  = 7'b0110011;
  localparam logic [6:0]  c_OPC_IMM = 7'b0010011;
  localparam logic [6:0]  c_OPC_LUI = 7'b0110111;

  logic [31:0] pc;
  logic [31:0] instrucao;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] read_data1, read_data2, write_back_data;
  logic [4:0]  prev_rd;
  logic        prev_RegWrite;
  logic        raw_hazard, pc_write, RegWrite, RegWrite_safe;

  logic [31:0] w_rom [IMEM_DEPTH];
  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm_i, w_imm_u, w_operand_b, w_alu;
  logic        w_is_op, w_is_opimm, w_is_lui, w_alt;
  logic        w_rs1_hz, w_rs2_hz;

  // ROM contents: program words first, NOP fill for the rest.
  for (genvar gi = 0; gi < IMEM_DEPTH; gi++) begin : g_rom
    if (gi < PROG_WORDS) begin : g_prog
      assign w_rom[gi] = PROGRAM[32*gi +: 32];
    end else begin : g_fill
      assign w_rom[gi] = NOP_WORD;
    end
  end

  // Fetch and field decode.
  assign instrucao  = w_rom[pc[AW+1:2]];
  assign w_opcode   = instrucao[6:0];
  assign rd         = instrucao[11:7];
  assign w_funct3   = instrucao[14:12];
  assign rs1        = instrucao[19:15];
  assign rs2        = instrucao[24:20];
  assign w_imm_i    = {{20{instrucao[31]}}, instrucao[31:20]};
  assign w_imm_u    = {instrucao[31:12], 12'd0};
  assign w_is_op    = (w_opcode == c_OPC_OP);
  assign w_is_opimm = (w_opcode == c_OPC_IMM);
  assign w_is_lui   = (w_opcode == c_OPC_LUI);
  assign RegWrite   = w_is_op | w_is_opimm | w_is_lui;

  // Bit 30 selects SUB/SRA; for immediates only SRAI uses it, since ADDI
  // with a negative immediate also carries bit 30.
  assign w_alt       = instrucao[30] &
                       (w_is_op ? ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))
                                : (w_funct3 == 3'b101));
  assign w_operand_b = w_is_op ? read_data2 : w_imm_i;

  cpu_core_regfile registradores (
    .clock    (clock),
    .reset    (reset),
    .i_raddr1 (rs1),
    .i_raddr2 (rs2),
    .i_we     (RegWrite_safe),
    .i_waddr  (rd),
    .i_wdata  (write_back_data),
    .o_rdata1 (read_data1),
    .o_rdata2 (read_data2)
  );

  // ALU shared by register and immediate forms.
  always_comb begin
    w_alu = 32'd0;
    case (w_funct3)
      3'b000: begin
        if (w_alt) w_alu = read_data1 - w_operand_b;
        else       w_alu = read_data1 + w_operand_b;
      end
      3'b001: w_alu = read_data1 << w_operand_b[4:0];
      3'b010: w_alu = {31'd0, $signed(read_data1) < $signed(w_operand_b)};
      3'b011: w_alu = {31'd0, read_data1 < w_operand_b};
      3'b100: w_alu = read_data1 ^ w_operand_b;
      3'b101: begin
        if (w_alt) w_alu = $signed(read_data1) >>> w_operand_b[4:0];
        else       w_alu = read_data1 >> w_operand_b[4:0];
      end
      3'b110: w_alu = read_data1 | w_operand_b;
      default: w_alu = read_data1 & w_operand_b;
    endcase
  end

  // Write-back selection and hazard detection.
  always_comb begin
    write_back_data = w_is_lui ? w_imm_u : w_alu;
    w_rs1_hz        = prev_RegWrite && (prev_rd != 5'd0) && (prev_rd == rs1);
    w_rs2_hz        = w_is_op && prev_RegWrite && (prev_rd != 5'd0) && (prev_rd == rs2);
    raw_hazard      = w_rs1_hz | w_rs2_hz;
    pc_write        = !raw_hazard;
    RegWrite_safe   = RegWrite && !raw_hazard;
  end

  // PC advance with wrap, and bookkeeping of the last issued writer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc            <= 32'd0;
      prev_rd       <= 5'd0;
      prev_RegWrite <= 1'b0;
    end else if (pc_write) begin
      pc            <= (pc == c_PC_LAST) ? 32'd0 : pc + 32'd4;
      prev_rd       <= rd;
      prev_RegWrite <= RegWrite_safe;
    end else begin
      prev_RegWrite <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_core
//  Description : Scoreboard bench for cpu_core; an instruction-level model
//                predicts each cycle's state, a monitor compares the probes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_core;

  localparam int          DEPTH   = 64;
  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] PC_LAST = 32'(DEPTH * 4 - 4);

  localparam logic [511:0] PROG_A = {{11{NOP}},
    32'hffb08293, 32'h40208233, 32'h002081b3, 32'h00300113, 32'h00a00093};

  // x0 write, LUI/SRAI, SUB underflow, SLT/SLTU, shifts, logic ops, an
  // unsupported opcode and several back-to-back dependencies.
  localparam logic [511:0] PROG_B = {
    32'hff04f913, 32'hfff0b893, 32'h00002023, 32'h00c7f833,
    32'h00d767b3, 32'h01f09713, 32'h0f04c693, 32'h0014d633,
    32'h0014a5b3, 32'h0090b533, 32'h401004b3, 32'h00100093,
    32'h4043d413, 32'h123453b7, 32'h00000333, 32'h00700013};

  typedef struct packed {
    logic [31:0]       pc;
    logic              stall;
    logic              pcw;
    logic              we;
    logic [31:0]       wb;
    logic [31:0][31:0] regs;
  } obs_t;

  logic clock = 1'b0;
  logic reset;
  logic rst_now;
  int   tests = 0;
  int   fails = 0;
  int   a_stalls = 0;
  logic [31:0] a_stall_pc = 32'd0;

  obs_t qa[$];
  obs_t qb[$];

  logic [31:0][31:0] mregs   [2];
  logic [31:0]       mpc     [2];
  logic [4:0]        mlastrd [2];
  logic              mlastw  [2];

  always #5 clock = ~clock;

  cpu_core #(.IMEM_DEPTH(DEPTH), .NOP_WORD(NOP), .PROG_WORDS(16), .PROGRAM(PROG_A))
    dut_a (.clock(clock), .reset(reset));
  cpu_core #(.IMEM_DEPTH(DEPTH), .NOP_WORD(NOP), .PROG_WORDS(16), .PROGRAM(PROG_B))
    dut_b (.clock(clock), .reset(reset));

  // ---------------- reference model ----------------
  function automatic logic [31:0] fetch(input int d, input logic [31:0] addr);
    int idx;
    logic [511:0] p;
    idx = int'(addr >> 2) % DEPTH;
    p = (d == 0) ? PROG_A : PROG_B;
    if (idx >= 16) return NOP;
    return p[32*idx +: 32];
  endfunction

  task automatic model_eval(input int d, output obs_t o, output logic [4:0] rdo);
    logic [31:0] w, a, b, res;
    logic signed [31:0] sa;
    logic [6:0] opc;
    logic [4:0] r1, r2, sh;
    logic is_op, known;
    w = fetch(d, mpc[d]);
    opc = w[6:0]; rdo = w[11:7]; r1 = w[19:15]; r2 = w[24:20];
    is_op = (opc == 7'h33);
    known = is_op || (opc == 7'h13) || (opc == 7'h37);
    a = mregs[d][r1];
    b = is_op ? mregs[d][r2] : {{20{w[31]}}, w[31:20]};
    sa = a; sh = b[4:0]; res = 32'd0;
    if (opc == 7'h37) res = {w[31:12], 12'h000};
    else begin
      case (w[14:12])
        3'd0: res = (is_op && w[30]) ? a - b : a + b;
        3'd1: res = a << sh;
        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: begin
          if (w[30]) res = sa >>> sh;
          else       res = a >> sh;
        end
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end
    o.pc    = mpc[d];
    o.stall = mlastw[d] && (mlastrd[d] != 5'd0) &&
              ((mlastrd[d] == r1) || (is_op && (mlastrd[d] == r2)));
    o.pcw   = !o.stall;
    o.we    = known && !o.stall;
    o.wb    = res;
    o.regs  = mregs[d];
  endtask

  task automatic model_reset(input int d);
    mpc[d] = 32'd0; mregs[d] = '0; mlastrd[d] = 5'd0; mlastw[d] = 1'b0;
  endtask

  task automatic model_step(input int d);
    obs_t o;
    logic [4:0] rdo;
    model_eval(d, o, rdo);
    if (o.stall) mlastw[d] = 1'b0;
    else begin
      if (o.we && (rdo != 5'd0)) mregs[d][rdo] = o.wb;
      mlastrd[d] = rdo;
      mlastw[d]  = o.we;
      mpc[d]     = (mpc[d] + 32'd4) % 32'(DEPTH * 4);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic next_rst);
    obs_t o;
    logic [4:0] rdo;
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      if (!rst_now) model_reset(d);
      else          model_step(d);
    end
    #2;
    model_eval(0, o, rdo); qa.push_back(o);
    model_eval(1, o, rdo); qb.push_back(o);
    reset   = next_rst;
    rst_now = next_rst;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] rega(input int i);
    return dut_a.registradores.registradores[i];
  endfunction
  function automatic logic [31:0] regb(input int i);
    return dut_b.registradores.registradores[i];
  endfunction

  task automatic check_a_final(input string tag);
    chk({tag, " x0"}, rega(0), 32'd0);
    chk({tag, " x1"}, rega(1), 32'd10);
    chk({tag, " x2"}, rega(2), 32'd3);
    chk({tag, " x3"}, rega(3), 32'd13);
    chk({tag, " x4"}, rega(4), 32'd7);
    chk({tag, " x5"}, rega(5), 32'd5);
  endtask

  // ---------------- monitor ----------------
  function automatic obs_t sample_a();
    obs_t o;
    o.pc = dut_a.pc; o.stall = dut_a.raw_hazard; o.pcw = dut_a.pc_write;
    o.we = dut_a.RegWrite_safe; o.wb = dut_a.write_back_data;
    for (int i = 0; i < 32; i++) o.regs[i] = dut_a.registradores.registradores[i];
    return o;
  endfunction

  function automatic obs_t sample_b();
    obs_t o;
    o.pc = dut_b.pc; o.stall = dut_b.raw_hazard; o.pcw = dut_b.pc_write;
    o.we = dut_b.RegWrite_safe; o.wb = dut_b.write_back_data;
    for (int i = 0; i < 32; i++) o.regs[i] = dut_b.registradores.registradores[i];
    return o;
  endfunction

  task automatic compare(input string who, input obs_t e, input obs_t a);
    chk({who, " pc"}, a.pc, e.pc);
    chk({who, " hazard/pc_write"}, {30'd0, a.stall, a.pcw}, {30'd0, e.stall, e.pcw});
    chk({who, " RegWrite_safe"}, {31'd0, a.we}, {31'd0, e.we});
    if (e.we) chk({who, " write_back_data"}, a.wb, e.wb);
    tests++;
    if (a.regs !== e.regs) begin
      fails++;
      for (int i = 0; i < 32; i++) begin
        if (a.regs[i] !== e.regs[i]) begin
          $display("FAIL %s regfile x%0d at pc %h: got %h want %h", who, i, e.pc,
                   a.regs[i], e.regs[i]);
          break;
        end
      end
    end
  endtask

  // Pop one expected state per DUT each cycle and compare with the probes.
  always @(negedge clock) begin
    obs_t act;
    obs_t exp;
    if (qa.size() > 0) begin
      exp = qa.pop_front();
      act = sample_a();
      compare("A", exp, act);
      if (act.stall) begin
        a_stalls++;
        a_stall_pc = act.pc;
      end
    end
    if (qb.size() > 0) begin
      exp = qb.pop_front();
      act = sample_b();
      compare("B", exp, act);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        found;
    logic        wrapped;
    logic [31:0] prev_pc;
    logic        zero_ok;
    reset = 1'b0; rst_now = 1'b0;
    for (int d = 0; d < 2; d++) model_reset(d);

    // Default program: one reset cycle, then 20 cycles.
    cycle(1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1);
    check_a_final("run1");
    chk("run1 stall count", 32'(a_stalls), 32'd1);
    chk("run1 stall pc", a_stall_pc, 32'd8);
    chk("B x0", regb(0), 32'd0);
    chk("B x6", regb(6), 32'd0);
    chk("B x7", regb(7), 32'h12345000);
    chk("B x8", regb(8), 32'h01234500);
    chk("B x9", regb(9), 32'hFFFFFFFF);

    // Mid-program reset at pc=12.
    reset = 1'b0; rst_now = 1'b0;
    cycle(1'b1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1'b1);
      if (dut_a.pc == 32'd12) found = 1'b1;
    end
    if (!found) begin
      tests++; fails++;
      $display("FAIL reach pc12: timed out, pc %h want %h", dut_a.pc, 32'd12);
    end
    reset = 1'b0; rst_now = 1'b0;
    cycle(1'b1);
    chk("midreset pc", dut_a.pc, 32'd0);
    zero_ok = 1'b1;
    for (int i = 0; i < 32; i++) if (rega(i) !== 32'd0) zero_ok = 1'b0;
    chk("midreset regs zero", {31'd0, zero_ok}, 32'd1);
    for (int i = 0; i < 20; i++) cycle(1'b1);
    check_a_final("rerun");

    // Run through the NOP fill until the PC wraps.
    a_stalls = 0;
    wrapped = 1'b0;
    for (int i = 0; i < 80 && !wrapped; i++) begin
      prev_pc = dut_a.pc;
      cycle(1'b1);
      if (prev_pc == PC_LAST && dut_a.pc == 32'd0) wrapped = 1'b1;
    end
    chk("pc wrap seen", {31'd0, wrapped}, 32'd1);
    chk("nop stall count", 32'(a_stalls), 32'd0);
    check_a_final("after wrap");

    // Random reset pulses; the scoreboard checks every cycle.
    for (int i = 0; i < 300; i++) cycle(($urandom_range(0, 11) != 0) ? 1'b1 : 1'b0);
    cycle(1'b1);

    @(negedge clock);
    #1;
    chk("scoreboard drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
